// File: rtl/onoc_pkg.sv
// Shared optical-NoC definitions.
// Holds the injection-port FSM state type and the default waveguide flit width
// used by the router-side injection blocks.
package onoc_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_SEND
  } tx_state_t;

  localparam int unsigned ONOC_FLIT_W_DEFAULT = 8;

endpackage

// File: rtl/onoc_pkt_fifo.sv
// Packet FIFO: parameterised width/depth synchronous FIFO with occupancy count.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (empties the FIFO)
//   push_i   write data_i (ignored when full)
//   data_i   write data
//   pop_i    drop the head entry (ignored when empty)
//   data_o   head entry (valid when count_o != 0)
//   count_o  number of stored entries, 0..Depth
module onoc_pkt_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (count_q != CntW'(Depth));
  assign pop_ok  = pop_i && (count_q != '0);

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/waveguide_tx_port.sv
// Waveguide injection port.
// Buffers whole packets from the router core, requests the waveguide arbiter
// while packets are pending, and on a one-cycle grant serialises the head
// packet onto the waveguide as exactly DELAY flits (flit 0 first).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     packet handshake from the router core
//   in_pkt                packet, flit 0 in the low FLIT_W bits
//   arb_req/arb_grant     request to / grant pulse from the arbiter
//   wg_valid/wg_data/wg_last  waveguide beat outputs (all register-driven)
//   occupancy             buffered packets, excluding the one in flight
//   tx_count              packets fully sent (wrapping)
//   err_grant             sticky: grant seen while not requesting
module waveguide_tx_port
  import onoc_pkg::*;
#(
  parameter int unsigned FLIT_W     = ONOC_FLIT_W_DEFAULT,
  parameter int unsigned DELAY      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DELAY*FLIT_W-1:0]       in_pkt,
  output logic                          arb_req,
  input  logic                          arb_grant,
  output logic                          wg_valid,
  output logic [FLIT_W-1:0]             wg_data,
  output logic                          wg_last,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [15:0]                   tx_count,
  output logic                          err_grant
);

  localparam int unsigned PktW  = DELAY * FLIT_W;
  localparam int unsigned OccW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BeatW = $clog2(DELAY);

  tx_state_t        state_q, state_d;
  logic [PktW-1:0]  shift_q, shift_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [15:0]      tx_count_q, tx_count_d;
  logic             err_q, err_d;

  logic [OccW-1:0]  occ;
  logic [PktW-1:0]  head_pkt;
  logic             push;
  logic             pop;
  logic             last_beat;

  assign in_ready  = (occ != OccW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == TX_REQ) && arb_grant;
  assign last_beat = (state_q == TX_SEND) && (beat_q == BeatW'(DELAY - 1));

  onoc_pkt_fifo #(
    .Width (PktW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (in_pkt),
    .pop_i   (pop),
    .data_o  (head_pkt),
    .count_o (occ)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    beat_d     = beat_q;
    tx_count_d = tx_count_q;
    // Any grant outside REQ is a protocol error; it has no other effect.
    err_d      = err_q | (arb_grant && (state_q != TX_REQ));
    unique case (state_q)
      TX_IDLE: begin
        if (occ != '0) begin
          state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        if (arb_grant) begin
          shift_d = head_pkt;
          beat_d  = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        shift_d = shift_q >> FLIT_W;
        beat_d  = beat_q + 1'b1;
        if (last_beat) begin
          beat_d     = '0;
          tx_count_d = tx_count_q + 16'd1;
          // No pop can occur in TX, so post-push occupancy is occ + push.
          state_d    = ((occ != '0) || push) ? TX_REQ : TX_IDLE;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      shift_q    <= '0;
      beat_q     <= '0;
      tx_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      beat_q     <= beat_d;
      tx_count_q <= tx_count_d;
      err_q      <= err_d;
    end
  end

  // Outputs decode registered state only; arb_grant never reaches them combinationally.
  assign arb_req   = (state_q == TX_REQ);
  assign wg_valid  = (state_q == TX_SEND);
  assign wg_last   = last_beat;
  assign wg_data   = wg_valid ? shift_q[FLIT_W-1:0] : '0;
  assign occupancy = occ;
  assign tx_count  = tx_count_q;
  assign err_grant = err_q;

endmodule

// File: tb/tb_waveguide_tx_port.sv
// Self-checking bench for waveguide_tx_port.
// A behavioural model (packet queue, beats-remaining counter, request flag) predicts
// every output each cycle; directed scenarios are followed by a randomised phase.
module tb_waveguide_tx_port;

  localparam int FLIT_W     = 8;
  localparam int DELAY      = 4;
  localparam int FIFO_DEPTH = 4;

  logic                        clk;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [DELAY*FLIT_W-1:0]     in_pkt;
  logic                        arb_req;
  logic                        arb_grant;
  logic                        wg_valid;
  logic [FLIT_W-1:0]           wg_data;
  logic                        wg_last;
  logic [$clog2(FIFO_DEPTH):0] occupancy;
  logic [15:0]                 tx_count;
  logic                        err_grant;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0] pq[$];
  logic [31:0] cur_pkt;
  int          m_left;
  int          m_beat;
  bit          m_req;
  bit          m_err;
  int          m_txc;

  waveguide_tx_port #(
    .FLIT_W     (FLIT_W),
    .DELAY      (DELAY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pkt    (in_pkt),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .wg_valid  (wg_valid),
    .wg_data   (wg_data),
    .wg_last   (wg_last),
    .occupancy (occupancy),
    .tx_count  (tx_count),
    .err_grant (err_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    pq.delete();
    cur_pkt = '0;
    m_left  = 0;
    m_beat  = 0;
    m_req   = 1'b0;
    m_err   = 1'b0;
    m_txc   = 0;
  endtask

  // One clock cycle: drive inputs, check all outputs mid-cycle, advance the model.
  task automatic cycle(input bit v, input logic [31:0] pkt, input bit g);
    int qs;
    bit acc;
    in_valid  = v;
    in_pkt    = pkt;
    arb_grant = g;
    @(negedge clk);
    qs = pq.size();
    chk("in_ready",  32'(in_ready),  32'(qs != FIFO_DEPTH));
    chk("occupancy", 32'(occupancy), 32'(qs));
    chk("arb_req",   32'(arb_req),   32'(m_req));
    chk("wg_valid",  32'(wg_valid),  32'(m_left > 0));
    chk("wg_data",   32'(wg_data),
        (m_left > 0) ? ((cur_pkt >> (FLIT_W * m_beat)) & 32'hff) : 32'h0);
    chk("wg_last",   32'(wg_last),   32'(m_left == 1));
    chk("tx_count",  32'(tx_count),  32'(m_txc));
    chk("err_grant", 32'(err_grant), 32'(m_err));
    acc = v && (qs != FIFO_DEPTH);
    if (m_left > 0) begin
      if (g) m_err = 1'b1;
      m_beat++;
      m_left--;
      if (m_left == 0) begin
        m_txc = (m_txc + 1) & 32'hffff;
        m_req = (qs + int'(acc)) > 0;
      end
    end else if (m_req) begin
      if (g) begin
        cur_pkt = pq.pop_front();
        m_left  = DELAY;
        m_beat  = 0;
        m_req   = 1'b0;
      end
    end else begin
      if (g) m_err = 1'b1;
      if (qs > 0) m_req = 1'b1;
    end
    if (acc) pq.push_back(pkt);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    arb_grant = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
  endtask

  // Advance until the model expects arb_req; bounded.
  task automatic wait_req();
    int n;
    n = 0;
    while (!m_req && n < 20) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    vectors++;
    assert (m_req) else begin
      miscompares++;
      $error("FAIL req_timeout: request not reached after %0d cycles", n);
    end
  endtask

  task automatic grant_and_send();
    wait_req();
    cycle(1'b0, 32'h0, 1'b1);
    idle(DELAY);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    arb_grant = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_arb_req",   32'(arb_req),   32'h0);
    chk("rst_wg_valid",  32'(wg_valid),  32'h0);
    chk("rst_wg_last",   32'(wg_last),   32'h0);
    chk("rst_wg_data",   32'(wg_data),   32'h0);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_tx_count",  32'(tx_count),  32'h0);
    chk("rst_err_grant", 32'(err_grant), 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    arb_grant = 1'b0;
    in_pkt    = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single packet, grant one cycle after arb_req rises.
    cycle(1'b1, 32'h44332211, 1'b0);
    wait_req();
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    idle(DELAY + 3);

    // Fill past capacity, then drain with grants spaced DELAY+1 apart.
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 4; i++) grant_and_send();
    idle(3);

    // Back-to-back packets.
    cycle(1'b1, $urandom, 1'b0);
    cycle(1'b1, $urandom, 1'b0);
    grant_and_send();
    grant_and_send();
    idle(3);

    // Spurious grants in IDLE and mid-TX.
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, $urandom, 1'b0);
    wait_req();
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    idle(DELAY + 2);

    // Push offered on the popping cycle: rejected at full, accepted at 2.
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0);
    wait_req();
    cycle(1'b1, $urandom, 1'b1);
    idle(DELAY);
    grant_and_send();
    wait_req();
    cycle(1'b1, $urandom, 1'b1);
    idle(DELAY);
    while (pq.size() > 0) grant_and_send();
    idle(2);

    // Reset at beat 2 of a transmission with packets still buffered.
    cycle(1'b1, $urandom, 1'b0);
    cycle(1'b1, $urandom, 1'b0);
    wait_req();
    cycle(1'b0, 32'h0, 1'b1);
    idle(2);
    do_reset();
    idle(2);
    cycle(1'b1, $urandom, 1'b0);
    grant_and_send();
    idle(2);

    // Randomised traffic including random (sometimes spurious) grants.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'h0, m_req);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/waveguide_tx_port.md
# waveguide_tx_port

Per-router injection stage upstream of the waveguide round-robin arbiter. Buffers whole packets from the router core, holds a request toward the arbiter while work is pending, and on a one-cycle grant pulse serializes the head packet onto the shared waveguide as exactly DELAY flits. It matches the arbiter's hold window, so the arbiter never re-grants while this port is driving.

## Interface
- FLIT_W, 8: bits per waveguide beat.
- DELAY, 4: beats per packet; must equal the arbiter's DELAY; ≥2.
- FIFO_DEPTH, 4: packet slots; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  core offers a packet.
- in_ready  out  1  port accepts; transfer when in_valid && in_ready.
- in_pkt  in  DELAY*FLIT_W  packet; flit 0 in bits [FLIT_W-1:0].
- arb_req  out  1  request line to the arbiter.
- arb_grant  in  1  one-cycle grant pulse from the arbiter.
- wg_valid  out  1  flit on waveguide this cycle.
- wg_data  out  FLIT_W  current flit.
- wg_last  out  1  final flit of the packet.
- occupancy  out  $clog2(FIFO_DEPTH)+1  packets buffered; excludes the packet in flight.
- tx_count  out  16  packets fully sent; wraps 0xFFFF→0.
- err_grant  out  1  sticky; set by a grant seen outside REQ.

## Operation
- FIFO: in_ready = (occupancy != FIFO_DEPTH). Push and pop in the same cycle leave occupancy unchanged. There is no bypass: a packet always spends at least one cycle in the FIFO.
- FSM states:
  - IDLE: go to REQ when occupancy > 0, evaluated on the registered occupancy.
  - REQ: arb_req=1. On arb_grant, pop the head into the shift register, clear beat_cnt and go to TX.
  - TX: arb_req=0 and wg_valid=1.
    - wg_data is shift[FLIT_W-1:0]. Each cycle the register shifts right by FLIT_W and beat_cnt increments.
    - wg_last=1 when beat_cnt==DELAY-1.
    - On the last beat: tx_count increments. Next state is REQ if occupancy after this cycle's push is > 0, otherwise IDLE.
- arb_req, wg_valid, wg_last and wg_data are driven from registers only; no combinational path from arb_grant.
- A grant in IDLE or TX is ignored, with no state or data effect, and sets err_grant. err_grant clears only on reset.
- A grant in REQ is honoured even if in_valid is asserted the same cycle.
- Outside TX, wg_data is zero.

## Timing
- Reset (async assert, sync deassert by the environment): state=IDLE, FIFO empty, in_ready=1, arb_req=0, wg_valid=0, wg_last=0, wg_data=0, occupancy=0, tx_count=0, err_grant=0.
- Reset mid-TX drops the in-flight and buffered packets; waveguide outputs go low immediately.
- Empty port, push at cycle 0 → arb_req=1 from cycle 2.
- Grant sampled at cycle g → wg_valid high for cycles g+1 … g+DELAY, with wg_last at g+DELAY.
- Back-to-back: if occupancy > 0 at the last beat, arb_req=1 at g+DELAY+1. This is the first cycle the arbiter can re-grant.
- Per-packet waveguide occupancy is exactly DELAY cycles, so there is no overlap with the arbiter's busy window.

## Structure
- Shared package onoc_pkg holds:
  - typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_SEND} tx_state_t
  - localparam ONOC_FLIT_W_DEFAULT = 8
- Sub-module onoc_pkt_fifo: parameterised width/depth synchronous FIFO with count output and asynchronous active-low reset. This block instantiates it with width DELAY*FLIT_W.
- The FSM, beat counter, shift register and statistics live in the top module.

## Test plan
- Single packet: push 0x44332211 (FLIT_W=8, DELAY=4), grant one cycle after arb_req rises → wg_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles; wg_last only on 0x44; tx_count=1; state returns to IDLE.
- Fill: 5 pushes with no grant → occupancy=4, in_ready=0 after the 4th, 5th not accepted. Then 4 grants spaced DELAY+1 apart → 4 packets out in order, tx_count=4.
- Back-to-back: two packets queued → arb_req drops during TX and reasserts exactly at g+DELAY+1; second packet's first beat at g'+1.
- Spurious grant: pulse arb_grant in IDLE and mid-TX → no wg_valid change, serialization unaffected, err_grant=1 and sticky.
- Simultaneous push/pop at full: occupancy=4, push offered the cycle grant pops → push rejected (in_ready was 0), occupancy=3 next cycle. Repeat at occupancy=2 → push accepted, occupancy stays 2.
- Reset at beat 2 of TX → all outputs at reset values immediately, in_ready=1, tx_count=0. Then a fresh packet transmits normally.
